// File: rtl/tie_cfg_pkg.sv
// Shared types for the tie-level controller: FSM state encoding and counter sizing.
// Build option TIE_CFG_PARITY_EN (see tie_cfg_ctrl) uses the CHECK state defined here.
package tie_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } tie_state_e;

  function automatic int cnt_width(input int n_bits);
    return $clog2(n_bits + 1);
  endfunction

endpackage

// File: rtl/tie_cfg_shadow.sv
// Shadow register for serially loaded tie levels: one-bit indexed write, bulk clear, XOR reduction.
// Build option TIE_CFG_PARITY_EN (see tie_cfg_ctrl) is the only consumer of par_o.
module tie_cfg_shadow #(
  parameter int                N_BITS    = 16,
  parameter logic [N_BITS-1:0] RESET_VAL = '0,
  parameter int                IDX_W     = 5
) (
  input  logic              ck,
  input  logic              nrst,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic              wr_bit_i,
  output logic [N_BITS-1:0] shadow_o,
  output logic              par_o
);

  logic [N_BITS-1:0] shadow_q;

  // Compare-per-bit write keeps the index width independent of N_BITS.
  always_ff @(posedge ck) begin
    if (!nrst || clr_i) begin
      shadow_q <= RESET_VAL;
    end else if (wr_en_i) begin
      for (int i = 0; i < N_BITS; i++) begin
        if (wr_idx_i == IDX_W'(i)) shadow_q[i] <= wr_bit_i;
      end
    end
  end

  assign shadow_o = shadow_q;
  assign par_o    = ^shadow_q;

endmodule

// File: rtl/tie_cfg_ctrl.sv
// Register-driven tie levels: serial LSB-first load into a shadow, atomic commit to tie_out.
// Define TIE_CFG_PARITY_EN for a trailing odd-parity bit (CHECK state, live cfg_err).
//
// state  | meaning
// IDLE   | ready, waiting for bit 0
// SHIFT  | collecting bits 1..N_BITS-1
// CHECK  | waiting for the parity bit (parity build only)
// COMMIT | shadow copied to tie_out at the closing edge, ready low
module tie_cfg_ctrl
  import tie_cfg_pkg::*;
#(
  parameter int                N_BITS    = 16,
  parameter logic [N_BITS-1:0] RESET_VAL = '0
) (
  input  logic              ck,
  input  logic              nrst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_bit,
  input  logic              cfg_abort,
  output logic [N_BITS-1:0] tie_out,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam int            CW       = cnt_width(N_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_BITS - 1);

  tie_state_e        state_q;
  logic [CW-1:0]     cnt_q;
  logic [N_BITS-1:0] tie_q;
  logic [N_BITS-1:0] shadow;
  logic              shadow_par;
  logic              ready_q;
  logic              done_q;
  logic              accept;
  logic              drop;
  logic              sh_wr;
  logic              sh_clr;
  logic [CW-1:0]     sh_idx;

  assign accept = cfg_valid & ready_q;
  assign drop   = cfg_abort & ((state_q == SHIFT) | (state_q == CHECK));
  assign sh_wr  = accept & ((state_q == IDLE) | ((state_q == SHIFT) & ~cfg_abort));
  assign sh_idx = (state_q == IDLE) ? '0 : cnt_q;

`ifdef TIE_CFG_PARITY_EN
  logic err_q;
  logic par_ok;

  assign par_ok  = shadow_par ^ cfg_bit;
  assign sh_clr  = drop | (accept & (state_q == CHECK) & ~par_ok);
  assign cfg_err = err_q;
`else
  logic par_unused;

  assign par_unused = shadow_par;
  assign sh_clr     = drop;
  assign cfg_err    = 1'b0;
`endif

  tie_cfg_shadow #(
    .N_BITS    (N_BITS),
    .RESET_VAL (RESET_VAL),
    .IDX_W     (CW)
  ) u_shadow (
    .ck       (ck),
    .nrst     (nrst),
    .clr_i    (sh_clr),
    .wr_en_i  (sh_wr),
    .wr_idx_i (sh_idx),
    .wr_bit_i (cfg_bit),
    .shadow_o (shadow),
    .par_o    (shadow_par)
  );

  // cfg_done/cfg_err are registered, so they appear the cycle after the deciding edge.
  always_ff @(posedge ck) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tie_q   <= RESET_VAL;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef TIE_CFG_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef TIE_CFG_PARITY_EN
      err_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            cnt_q   <= CW'(1);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cfg_abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (accept) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
`ifdef TIE_CFG_PARITY_EN
              state_q <= CHECK;
`else
              state_q <= COMMIT;
              ready_q <= 1'b0;
`endif
            end
          end
        end
`ifdef TIE_CFG_PARITY_EN
        CHECK: begin
          if (cfg_abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (accept) begin
            if (par_ok) begin
              state_q <= COMMIT;
              ready_q <= 1'b0;
            end else begin
              err_q   <= 1'b1;
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
        end
`endif
        COMMIT: begin
          tie_q   <= shadow;
          done_q  <= 1'b1;
          state_q <= IDLE;
          cnt_q   <= '0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready = ready_q;
  assign tie_out   = tie_q;
  assign cfg_done  = done_q;

endmodule

// File: tb/tb_tie_cfg_ctrl.sv
// Randomized bench for tie_cfg_ctrl against a queue-based reference of accepted bits.
// Honours TIE_CFG_PARITY_EN by appending a parity bit to every load.
module tb_tie_cfg_ctrl;

  localparam int          N  = 16;
  localparam logic [N-1:0] RV = '0;
`ifdef TIE_CFG_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic         ck = 1'b0;
  logic         nrst;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         cfg_bit;
  logic         cfg_abort;
  logic [N-1:0] tie_out;
  logic         cfg_done;
  logic         cfg_err;

  always #5 ck = ~ck;

  tie_cfg_ctrl #(
    .N_BITS    (N),
    .RESET_VAL (RV)
  ) dut (
    .ck        (ck),
    .nrst      (nrst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_bit   (cfg_bit),
    .cfg_abort (cfg_abort),
    .tie_out   (tie_out),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  int           n_chk = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           last_tie_chg = 0;
  int           done_cnt = 0;
  int           err_cnt = 0;
  logic [N-1:0] prev_tie;

  // Reference: bits accepted so far in the current load, plus pending commit flag.
  bit           m_q[$];
  logic [N-1:0] m_tie;
  bit           m_ready;
  bit           m_done;
  bit           m_err;
  bit           m_commit;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] m_pack();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_q[i];
    return v;
  endfunction

  task automatic model_edge(input bit v, input bit b, input bit a, input bit r);
    bit x;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!r) begin
      m_q.delete();
      m_tie    = RV;
      m_ready  = 1'b0;
      m_commit = 1'b0;
      return;
    end
    if (m_commit) begin
      m_tie    = m_pack();
      m_done   = 1'b1;
      m_commit = 1'b0;
      m_q.delete();
    end else if (a && m_q.size() > 0) begin
      m_q.delete();
    end else if (v && m_ready) begin
      m_q.push_back(b);
      if (m_q.size() == N + PB) begin
        x = 1'b0;
        foreach (m_q[i]) x ^= m_q[i];
        if (PB == 0 || x) begin
          m_commit = 1'b1;
        end else begin
          m_err = 1'b1;
          m_q.delete();
        end
      end
    end
    m_ready = !m_commit;
  endtask

  task automatic step(input bit v, input bit b, input bit a, input bit r);
    cfg_valid = v;
    cfg_bit   = b;
    cfg_abort = a;
    nrst      = r;
    @(posedge ck);
    model_edge(v, b, a, r);
    cyc++;
    #1;
    check_val("tie_out", tie_out, m_tie);
    check_val("cfg_done", cfg_done, m_done);
    check_val("cfg_ready", cfg_ready, m_ready);
    check_val("cfg_err", cfg_err, m_err);
    if (cfg_done) done_cnt++;
    if (cfg_err) err_cnt++;
    if (tie_out !== prev_tie) last_tie_chg = cyc;
    prev_tie = tie_out;
  endtask

  task automatic load(input logic [N-1:0] data, input int prob, input bit bad_par,
                      input int abort_after, input bit rst_commit, output int first_acc);
    bit s[$];
    bit v;
    bit acc;
    int idx;
    int guard;
    for (int i = 0; i < N; i++) s.push_back(data[i]);
    if (PB == 1) s.push_back(~(^data) ^ bad_par);
    idx       = 0;
    guard     = 0;
    first_acc = -1;
    while (idx < s.size() && guard < 2000) begin
      if (abort_after == idx) begin
        step(1'b1, s[idx], 1'b1, 1'b1);
        idx = s.size();
      end else begin
        v   = ($urandom_range(99) < prob);
        acc = v && m_ready;
        step(v, s[idx], 1'b0, 1'b1);
        if (acc) begin
          if (first_acc < 0) first_acc = cyc;
          idx++;
        end
      end
      guard++;
    end
    check_val("load_timeout", guard >= 2000, 0);
    if (rst_commit) begin
      check_val("commit_ready_low", cfg_ready, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end else begin
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           fa;
    logic [N-1:0] d;
    int           ab;
    bit           bp;

    prev_tie = 'x;
    m_tie    = RV;
    m_ready  = 1'b0;
    m_commit = 1'b0;

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("rst_tie", tie_out, RV);
    check_val("rst_ready", cfg_ready, 0);
    check_val("rst_done", cfg_done, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("ready_after_rst", cfg_ready, 1);

    done_cnt = 0;
    load(16'hA5C3, 100, 1'b0, -1, 1'b0, fa);
    check_val("a5c3_value", tie_out, 16'hA5C3);
    check_val("a5c3_done_pulses", done_cnt, 1);
    check_val("a5c3_edges_incl_accept", last_tie_chg - fa + 1, N + 1 + PB);

    done_cnt = 0;
    load(16'h5A3C, 100, 1'b0, -1, 1'b0, fa);
    load(16'hA5C3, 40, 1'b0, -1, 1'b0, fa);
    check_val("a5c3_gappy_value", tie_out, 16'hA5C3);
    check_val("gappy_done_pulses", done_cnt, 2);

    done_cnt = 0;
    load(16'h1234, 100, 1'b0, 7, 1'b0, fa);
    check_val("abort_no_done", done_cnt, 0);
    check_val("abort_tie_kept", tie_out, 16'hA5C3);
    load(16'h00FF, 70, 1'b0, -1, 1'b0, fa);
    check_val("after_abort_value", tie_out, 16'h00FF);
    check_val("after_abort_done", done_cnt, 1);

`ifdef TIE_CFG_PARITY_EN
    done_cnt = 0;
    err_cnt  = 0;
    load(16'hFFFF, 100, 1'b0, -1, 1'b0, fa);
    check_val("par_good_value", tie_out, 16'hFFFF);
    check_val("par_good_done", done_cnt, 1);
    load(16'h0F0F, 100, 1'b0, -1, 1'b0, fa);
    done_cnt = 0;
    load(16'hFFFF, 100, 1'b1, -1, 1'b0, fa);
    check_val("par_bad_err", err_cnt, 1);
    check_val("par_bad_no_done", done_cnt, 0);
    check_val("par_bad_tie_kept", tie_out, 16'h0F0F);
`endif

    for (int k = 0; k < 10; k++) begin
      d  = N'($urandom);
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(N - 1, 1)) : -1;
      bp = (PB == 1) ? bit'($urandom_range(1)) : 1'b0;
      load(d, $urandom_range(100, 30), bp, ab, 1'b0, fa);
    end

    load(16'hBEEF, 100, 1'b0, -1, 1'b0, fa);
    check_val("pre_rst_value", tie_out, 16'hBEEF);
    done_cnt = 0;
    load(16'h7E57, 100, 1'b0, -1, 1'b1, fa);
    check_val("rst_commit_tie", tie_out, RV);
    check_val("rst_commit_no_done", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
